clk_div_cfg_ctrl: RTL and testbench

Runtime configuration sequencer for the integer clock divider. Accepts divide-value update requests over a valid/ready interface and validates them. Sequences a glitch-free change: gate the divided clock off, load the new value into the divider with a handshake, wait a settle window, then re-enable the gate. Sits between the register/config interface and the divider instance plus its output clock gate.

---
 rtl/clk_div_ctrl_pkg.sv | 25 ++
 rtl/clk_div_ctrl_cnt.sv | 28 ++
 rtl/clk_div_cfg_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the clock-divider configuration sequencer.
// State and error-code encodings plus a small sizing helper.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_OFF = 2'd1,
    LOAD     = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ZERO    = 2'd1,
    ERR_ODD     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
// One instance serves the gate-off, load-timeout and settle windows.
module clk_div_ctrl_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Runtime divide-value update sequencer: validate, gate off, load with handshake,
// settle, then re-enable the divided-clock gate.
//
// state    | meaning
// IDLE     | accepting requests, gate follows en_i
// GATE_OFF | gate held off before the load
// LOAD     | strobe new value to divider, wait for ready or timeout
// SETTLE   | divider settling, gate still off
module clk_div_cfg_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_VALUE_WIDTH   = 8,
  parameter int DEFAULT_DIV_VALUE = 4,
  parameter int GATE_CYCLES       = 2,
  parameter int SETTLE_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES    = 16,
  parameter int EVEN_ONLY         = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic                       en_i,
  output logic [DIV_VALUE_WIDTH-1:0] div_value_o,
  output logic                       div_valid_o,
  input  logic                       div_ready_i,
  output logic                       clk_gate_en_o,
  output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o
);

  localparam int CNT_MAX = max3(GATE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DIV_VALUE_WIDTH-1:0] DEF_DIV = DIV_VALUE_WIDTH'(DEFAULT_DIV_VALUE);

  state_t                     r_state;
  err_code_t                  r_code;
  logic [DIV_VALUE_WIDTH-1:0] r_cur;
  logic [DIV_VALUE_WIDTH-1:0] r_new;
  logic [DIV_VALUE_WIDTH-1:0] r_div_value;
  logic                       r_div_valid;
  logic                       r_gate;
  logic                       r_ready;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;
  logic                       r_abort;

  logic             w_accept;
  logic             w_is_zero;
  logic             w_is_odd;
  logic             w_is_same;
  logic             w_start;
  logic             w_cnt_zero;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;

  assign w_accept  = cfg_valid_i && r_ready;
  assign w_is_zero = (cfg_div_i == '0);
  assign w_is_odd  = (EVEN_ONLY != 0) && cfg_div_i[0];
  assign w_is_same = (cfg_div_i == r_cur);
  assign w_start   = w_accept && !w_is_zero && !w_is_odd && !w_is_same;

  // Each window loads its length minus one so it lasts exactly that many cycles.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: if (w_start) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(GATE_CYCLES - 1);
      end
      GATE_OFF: if (w_cnt_zero) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(TIMEOUT_CYCLES - 1);
      end
      LOAD: if (div_ready_i || w_cnt_zero) begin
        w_load     = 1'b1;
        w_load_val = CNT_W'(SETTLE_CYCLES - 1);
      end
      default: ;
    endcase
  end

  clk_div_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (!w_load),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_code      <= ERR_NONE;
      r_cur       <= DEF_DIV;
      r_new       <= DEF_DIV;
      r_div_value <= DEF_DIV;
      r_div_valid <= 1'b0;
      r_gate      <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gate  <= en_i;
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_is_zero) begin
              r_err  <= 1'b1;
              r_code <= ERR_ZERO;
            end else if (w_is_odd) begin
              r_err  <= 1'b1;
              r_code <= ERR_ODD;
            end else if (w_is_same) begin
              r_done <= 1'b1;
              r_code <= ERR_NONE;
            end else begin
              r_new   <= cfg_div_i;
              r_state <= GATE_OFF;
              r_gate  <= 1'b0;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_code  <= ERR_NONE;
              r_abort <= 1'b0;
            end
          end
        end
        GATE_OFF: if (w_cnt_zero) begin
          r_state     <= LOAD;
          r_div_valid <= 1'b1;
          r_div_value <= r_new;
        end
        LOAD: begin
          if (div_ready_i) begin
            r_cur       <= r_new;
            r_div_valid <= 1'b0;
            r_state     <= SETTLE;
          end else if (w_cnt_zero) begin
            // Abort: divider keeps the old value, still give it a settle window.
            r_div_valid <= 1'b0;
            r_div_value <= r_cur;
            r_err       <= 1'b1;
            r_code      <= ERR_TIMEOUT;
            r_abort     <= 1'b1;
            r_state     <= SETTLE;
          end
        end
        SETTLE: if (w_cnt_zero) begin
          r_state <= IDLE;
          r_gate  <= en_i;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= !r_abort;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_ready_o   = r_ready;
  assign div_value_o   = r_div_value;
  assign div_valid_o   = r_div_valid;
  assign clk_gate_en_o = r_gate;
  assign cur_div_o     = r_cur;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign err_code_o    = r_code;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed scenarios plus randomized
// requests checked cycle by cycle against a timeline model of the sequence.
module tb_clk_div_cfg_ctrl;

  localparam int G = 2;
  localparam int S = 4;
  localparam int T = 16;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] cfg_div_i;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic       en_i;
  logic [7:0] div_value_o;
  logic       div_valid_o;
  logic       div_ready_i;
  logic       clk_gate_en_o;
  logic [7:0] cur_div_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [1:0] err_code_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_cur;
  logic [1:0] m_code;

  clk_div_cfg_ctrl dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .cfg_div_i     (cfg_div_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .en_i          (en_i),
    .div_value_o   (div_value_o),
    .div_valid_o   (div_valid_o),
    .div_ready_i   (div_ready_i),
    .clk_gate_en_o (clk_gate_en_o),
    .cur_div_o     (cur_div_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One request from IDLE. delay = LOAD cycles before the divider answers
  // (>= T means never); flip_k = sample index at which en_i toggles (-1: none).
  task automatic do_request(input logic [7:0] v, input int delay, input logic en_val,
                            input int flip_k);
    logic [7:0] old, e_cur, e_dv;
    logic [5:0] act, e_fl;
    logic [1:0] e_code0, e_codeN;
    logic       en_fin;
    int kind, L, E, last, vcnt;
    bit to;
    old = m_cur;
    if (v == 0) kind = 0;
    else if (v[0]) kind = 1;
    else if (v == old) kind = 2;
    else kind = 3;
    to   = (kind == 3) && (delay >= T);
    L    = to ? T : delay + 1;
    E    = G + L + S;
    last = (kind == 3) ? E + 1 : 1;
    en_fin  = (kind == 3 && flip_k >= 0 && flip_k < E) ? ~en_val : en_val;
    e_code0 = (kind == 0) ? 2'd1 : (kind == 1) ? 2'd2 : 2'd0;
    e_codeN = (kind == 3 && to) ? 2'd3 : e_code0;
    en_i = en_val;
    div_ready_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL req_ready v=%0d act=%b exp=1", v, cfg_ready_o);
    end
    cfg_div_i = v;
    cfg_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
    vcnt = 0;
    for (int k = 0; k <= last; k++) begin
      if (kind != 3) begin
        e_fl  = {1'b1, 1'b0, en_val, 1'b0, (k == 0 && kind == 2), (k == 0 && kind < 2)};
        e_cur = old;
        e_dv  = old;
      end else begin
        e_cur = (!to && k >= G + L) ? v : old;
        e_dv  = (k >= G && k < G + L) ? v : e_cur;
        e_fl  = {(k >= E), (k >= G && k < G + L), (k >= E) ? en_fin : 1'b0,
                 (k < E), (k == E && !to), (to && k == G + L)};
      end
      act = {cfg_ready_o, div_valid_o, clk_gate_en_o, busy_o, done_o, err_o};
      checks++;
      if (act !== e_fl) begin
        errors++;
        $display("FAIL flags v=%0d k=%0d act=%b exp=%b (rdy,vld,gate,busy,done,err)",
                 v, k, act, e_fl);
      end
      checks++;
      if (cur_div_o !== e_cur) begin
        errors++;
        $display("FAIL cur_div v=%0d k=%0d act=%0d exp=%0d", v, k, cur_div_o, e_cur);
      end
      if (kind != 3 || k >= G) begin
        checks++;
        if (div_value_o !== e_dv) begin
          errors++;
          $display("FAIL div_value v=%0d k=%0d act=%0d exp=%0d", v, k, div_value_o, e_dv);
        end
      end
      if (k == 0 || k == last) begin
        checks++;
        if (err_code_o !== ((k == 0) ? e_code0 : e_codeN)) begin
          errors++;
          $display("FAIL err_code v=%0d k=%0d act=%0d exp=%0d", v, k, err_code_o,
                   (k == 0) ? e_code0 : e_codeN);
        end
      end
      if (div_valid_o === 1'b1) vcnt++;
      div_ready_i = (div_valid_o === 1'b1) && (delay < T) && (vcnt > delay);
      if (kind == 3 && k == flip_k && flip_k < E) en_i = ~en_val;
      if (k < last) begin
        @(posedge clk_i); #1;
      end
    end
    div_ready_i = 1'b0;
    if (kind == 3 && !to) m_cur = v;
    m_code = e_codeN;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    en_i = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_div_i = 8'd0;
    div_ready_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({cfg_ready_o, clk_gate_en_o, div_valid_o, busy_o, done_o, err_o, err_code_o} !== 8'b0 ||
        cur_div_o !== 8'd4 || div_value_o !== 8'd4) begin
      errors++;
      $display("FAIL reset_vals rdy=%b gate=%b vld=%b busy=%b done=%b err=%b code=%0d cur=%0d dv=%0d exp all0 cur=4 dv=4",
               cfg_ready_o, clk_gate_en_o, div_valid_o, busy_o, done_o, err_o, err_code_o,
               cur_div_o, div_value_o);
    end
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release act=%b exp=1", cfg_ready_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (clk_gate_en_o !== 1'b1 || cur_div_o !== 8'd4 || div_value_o !== 8'd4) begin
      errors++;
      $display("FAIL post_release gate=%b cur=%0d dv=%0d exp gate=1 cur=4 dv=4",
               clk_gate_en_o, cur_div_o, div_value_o);
    end
    m_cur = 8'd4;
    m_code = 2'd0;
  endtask

  task automatic test_random();
    logic [7:0] v;
    int cat, fl;
    for (int i = 0; i < 14; i++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0: v = 8'd0;
        1: v = 8'($urandom_range(0, 127) * 2 + 1);
        2: v = m_cur;
        default: begin
          v = 8'($urandom_range(1, 127) * 2);
          while (v == m_cur) v = 8'($urandom_range(1, 127) * 2);
        end
      endcase
      fl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1;
      do_request(v, $urandom_range(0, 20), 1'($urandom_range(0, 1)), fl);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    int k_done;
    bit found;
    a = (m_cur != 8'd8) ? 8'd8 : 8'd10;
    b = (m_cur != 8'd12) ? 8'd12 : 8'd14;
    en_i = 1'b1;
    div_ready_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_div_i = a;
    cfg_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_div_i = b;
    k_done = -1;
    for (int k = 0; k <= 20 && k_done < 0; k++) begin
      if (done_o === 1'b1) k_done = k;
      else begin
        @(posedge clk_i); #1;
      end
    end
    checks++;
    if (k_done != G + 1 + S) begin
      errors++;
      $display("FAIL b2b_first_done act_k=%0d exp_k=%0d", k_done, G + 1 + S);
    end
    @(posedge clk_i); #1;
    checks++;
    if (busy_o !== 1'b1 || cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept busy=%b rdy=%b exp busy=1 rdy=0", busy_o, cfg_ready_o);
    end
    cfg_valid_i = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1) found = 1;
    end
    checks++;
    if (!found || cur_div_o !== b || clk_gate_en_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done found=%0d cur=%0d gate=%b exp found=1 cur=%0d gate=1",
               found, cur_div_o, clk_gate_en_o, b);
    end
    div_ready_i = 1'b0;
    m_cur = b;
    m_code = 2'd0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    bit found;
    v = (m_cur != 8'd6) ? 8'd6 : 8'd10;
    en_i = 1'b1;
    div_ready_i = 1'b0;
    @(posedge clk_i); #1;
    cfg_div_i = v;
    cfg_valid_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_valid_i = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (div_valid_o === 1'b1) found = 1;
      else begin
        @(posedge clk_i); #1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach_load act=0 exp=1");
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({clk_gate_en_o, div_valid_o, cfg_ready_o, busy_o, done_o, err_o, err_code_o} !== 8'b0 ||
        cur_div_o !== 8'd4 || div_value_o !== 8'd4) begin
      errors++;
      $display("FAIL mid_reset gate=%b vld=%b rdy=%b busy=%b cur=%0d dv=%0d exp 0,0,0,0 cur=4 dv=4",
               clk_gate_en_o, div_valid_o, cfg_ready_o, busy_o, cur_div_o, div_value_o);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    m_cur = 8'd4;
    m_code = 2'd0;
    do_request(8'd8, 0, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    do_request(8'd0, 0, 1'b1, -1);
    do_request(8'd5, 0, 1'b1, -1);
    do_request(8'd4, 0, 1'b1, -1);
    do_request(8'd8, 0, 1'b1, -1);
    do_request(8'd6, 20, 1'b1, -1);
    do_request(8'd6, 15, 1'b1, -1);
    do_request(8'd10, 3, 1'b1, 4);
    do_request(8'd12, 1, 1'b0, -1);
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
